// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel divider, x/y raster counters, sync/active decode
// and a one-pixel registered output stage with a selectable test pattern.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 12,
    parameter int unsigned XW       = 10,
    parameter int unsigned YW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] sw,
    input  logic [CW-1:0] rgb_in,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          pix_tick,
    output logic          line_start,
    output logic          frame_start,
    output logic          hsync,
    output logic          vsync,
    output logic          vOn,
    output logic [CW-1:0] rgb
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
    localparam int unsigned CC      = CW / 3;

    logic [DW-1:0] div;
    logic [1:0]    mode_q;
    logic          x_last;
    logic          y_last;
    logic          act;
    logic          hs;
    logic          vs;
    logic [XW-1:0] bar_idx;
    logic [2:0]    bar_k;
    logic [CW-1:0] pat;

    assign pix_tick = (div == DW'(CLK_DIV - 1));
    assign x_last   = (x == XW'(H_TOTAL - 1));
    assign y_last   = (y == YW'(V_TOTAL - 1));

    // Pixel divider and raster counters; en low restarts everything synchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div         <= '0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (!en) begin
            div         <= '0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= pix_tick ? '0 : div + DW'(1);
            line_start  <= pix_tick && x_last;
            frame_start <= pix_tick && x_last && y_last;
            if (pix_tick) begin
                x <= x_last ? '0 : x + XW'(1);
                if (x_last) begin
                    y <= y_last ? '0 : y + YW'(1);
                end
            end
        end
    end

    // Pattern select is sampled once per frame so a frame never mixes sources
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= 2'd0;
        end else if (en && frame_start) begin
            mode_q <= mode;
        end
    end

    // Sync/active decode and test-pattern colour for the current x,y
    always_comb begin
        act     = (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));
        hs      = ~HS_POL;
        vs      = ~VS_POL;
        bar_idx = x / XW'(BAR_W);
        bar_k   = (bar_idx > XW'(7)) ? 3'd7 : bar_idx[2:0];
        pat     = '0;
        if ((x >= XW'(H_ACTIVE + H_FP)) && (x < XW'(H_ACTIVE + H_FP + H_SYNC))) begin
            hs = HS_POL;
        end
        if ((y >= YW'(V_ACTIVE + V_FP)) && (y < YW'(V_ACTIVE + V_FP + V_SYNC))) begin
            vs = VS_POL;
        end
        case (mode_q)
            2'd0: pat = rgb_in;
            2'd1: pat = sw;
            2'd2: pat = {{CC{bar_k[2]}}, {CC{bar_k[1]}}, {CC{bar_k[0]}}};
            default: begin
                if ((x == '0) || (x == XW'(H_ACTIVE - 1)) ||
                    (y == '0) || (y == YW'(V_ACTIVE - 1))) begin
                    pat = sw;
                end
            end
        endcase
    end

    // One-pixel output stage; uses the pre-wrap x,y on the tick edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
            vOn   <= 1'b0;
            rgb   <= '0;
        end else if (!en) begin
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
            vOn   <= 1'b0;
            rgb   <= '0;
        end else if (pix_tick) begin
            hsync <= hs;
            vsync <= vs;
            vOn   <= act;
            rgb   <= act ? pat : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster; expected outputs derive from
// the clock count since restart using plain arithmetic.
module tb_vga_timing_gen;

    localparam int D   = 3;
    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HSY = 3;
    localparam int HBP = 3;
    localparam int VA  = 8;
    localparam int VFP = 1;
    localparam int VSY = 2;
    localparam int VBP = 2;
    localparam bit HSP = 1'b0;
    localparam bit VSP = 1'b1;
    localparam int HT  = HA + HFP + HSY + HBP;   // 24
    localparam int VT  = VA + VFP + VSY + VBP;   // 13
    localparam int LT  = D * HT;                 // 72 clks per line
    localparam int FT  = LT * VT;                // 936 clks per frame

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [11:0] sw;
    logic [11:0] rgb_in;
    logic [4:0]  x;
    logic [3:0]  y;
    logic        pix_tick;
    logic        line_start;
    logic        frame_start;
    logic        hsync;
    logic        vsync;
    logic        vOn;
    logic [11:0] rgb;

    vga_timing_gen #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .CW(12), .XW(5), .YW(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sw(sw), .rgb_in(rgb_in),
        .x(x), .y(y), .pix_tick(pix_tick), .line_start(line_start),
        .frame_start(frame_start), .hsync(hsync), .vsync(vsync), .vOn(vOn), .rgb(rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    int cyc;

    // Model state: clocks since restart plus the registered-output expectations
    int          n;
    logic [1:0]  m_lat;
    logic        e_hs, e_vs, e_von, e_ls, e_fs;
    logic [11:0] e_rgb;
    int          mx, my;
    bit          mt;

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic cur();
        int p;
        p  = n / D;
        mx = p % HT;
        my = (p / HT) % VT;
        mt = ((n % D) == D - 1);
    endtask

    function automatic logic [11:0] pat(input int px, input int py, input logic [1:0] m,
                                        input logic [11:0] s, input logic [11:0] r);
        int k;
        case (m)
            2'd0: return r;
            2'd1: return s;
            2'd2: begin
                k = px / (HA / 8);
                if (k > 7) k = 7;
                return {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
            end
            default: return (px == 0 || px == HA - 1 || py == 0 || py == VA - 1) ? s : 12'h000;
        endcase
    endfunction

    task automatic model_reset(input bit keep_mode);
        n     = 0;
        e_hs  = ~HSP;
        e_vs  = ~VSP;
        e_von = 1'b0;
        e_rgb = 12'h000;
        e_ls  = 1'b0;
        e_fs  = 1'b0;
        if (!keep_mode) m_lat = 2'd0;
    endtask

    // Predict the effect of the coming clock edge given the inputs now applied
    task automatic model_step();
        bit a;
        if (!en) begin
            model_reset(1'b1);
        end else begin
            cur();
            if (mt) begin
                a     = (mx < HA) && (my < VA);
                e_von = a;
                e_hs  = (mx >= HA + HFP && mx < HA + HFP + HSY) ? HSP : ~HSP;
                e_vs  = (my >= VA + VFP && my < VA + VFP + VSY) ? VSP : ~VSP;
                e_rgb = a ? pat(mx, my, m_lat, sw, rgb_in) : 12'h000;
            end
            if (e_fs) m_lat = mode;
            n++;
            e_ls = (n % LT) == 0;
            e_fs = (n % FT) == 0;
        end
    endtask

    task automatic compare();
        cur();
        chk("x",           int'(x),           mx);
        chk("y",           int'(y),           my);
        chk("pix_tick",    int'(pix_tick),    int'(mt));
        chk("line_start",  int'(line_start),  int'(e_ls));
        chk("frame_start", int'(frame_start), int'(e_fs));
        chk("hsync",       int'(hsync),       int'(e_hs));
        chk("vsync",       int'(vsync),       int'(e_vs));
        chk("vOn",         int'(vOn),         int'(e_von));
        chk("rgb",         int'(rgb),         int'(e_rgb));
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk);
        cyc++;
        compare();
    endtask

    task automatic async_reset();
        rst = 1'b0;
        #1;
        model_reset(1'b0);
        compare();
        rst = 1'b1;
    endtask

    initial begin
        int first_tick, ls0, ls1, fs0, fs1, hs_cnt, vs_cnt, von_cnt;
        bit p_t;
        int p_x, p_y;
        n_vec = 0; n_err = 0; cyc = 0;
        rst = 1'b0; en = 1'b1; mode = 2'd0; sw = 12'h0FF; rgb_in = 12'h000;
        model_reset(1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Warm-up into the middle of a frame, then a mid-frame async reset
        for (int i = 0; i < 500; i++) begin
            rgb_in = 12'($urandom);
            cycle();
        end
        rst = 1'b0;
        #1;
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 0);
        chk("rst_vOn",   int'(vOn),   0);
        chk("rst_rgb",   int'(rgb),   0);
        chk("rst_x",     int'(x),     0);
        chk("rst_y",     int'(y),     0);
        model_reset(1'b0);
        compare();
        rst = 1'b1;

        // Directed run: three frames with colour bars requested
        mode = 2'd2;
        cyc = 0;
        first_tick = -1; ls0 = -1; ls1 = -1; fs0 = -1; fs1 = -1;
        hs_cnt = 0; vs_cnt = 0; von_cnt = 0;
        p_t = 1'b0; p_x = 0; p_y = 0;
        for (int i = 0; i < 3 * FT; i++) begin
            rgb_in = 12'($urandom);
            cycle();
            if (pix_tick && first_tick < 0) first_tick = cyc;
            if (line_start) begin
                if (ls0 < 0) ls0 = cyc; else if (ls1 < 0) ls1 = cyc;
            end
            if (frame_start) begin
                if (fs0 < 0) fs0 = cyc; else if (fs1 < 0) fs1 = cyc;
            end
            if (cyc >= FT && cyc < FT + LT && hsync == HSP) hs_cnt++;
            if (cyc >= FT && cyc < 2 * FT) begin
                if (vsync == VSP) vs_cnt++;
                if (vOn) von_cnt++;
                if (p_t && p_y == 1) begin
                    case (p_x)
                        1:  chk("bar_x1",  int'(rgb), 'h000);
                        2:  chk("bar_x2",  int'(rgb), 'h00F);
                        8:  chk("bar_x8",  int'(rgb), 'hF00);
                        15: chk("bar_x15", int'(rgb), 'hFFF);
                        default: ;
                    endcase
                end
            end
            p_t = mt; p_x = mx; p_y = my;
        end
        chk("first_tick_clk",   first_tick,  D - 1);
        chk("first_line_start", ls0,         LT);
        chk("line_period",      ls1 - ls0,   LT);
        chk("first_frame",      fs0,         FT);
        chk("frame_period",     fs1 - fs0,   FT);
        chk("hsync_active_clks", hs_cnt,     HSY * D);
        chk("vsync_active_clks", vs_cnt,     VSY * LT);
        chk("von_clks_frame",   von_cnt,     HA * VA * D);

        // Randomised run: enable drops, mode/sw changes and rare async resets
        for (int i = 0; i < 20000; i++) begin
            en     = ($urandom % 150) != 0;
            rgb_in = 12'($urandom);
            if ($urandom % 400 == 0) mode = 2'($urandom);
            if ($urandom % 300 == 0) sw = 12'($urandom);
            if ($urandom % 5000 == 0) async_reset();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
